game_delay_timer: RTL and testbench

- Timed-delay responder for the game control FSM.
- The FSM issues a one-cycle requestTime with a tick count on slowClkRequest, e.g. 120 ticks for the level-transition screen.
- This block counts that many prescaled ticks, then returns a one-cycle slowClk pulse that advances the FSM.
- Sits between the game FSM and the system clock; one outstanding delay at a time; a new request retriggers.

---
 rtl/game_delay_timer.sv | 105 ++++++++++
 tb/tb_game_delay_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_delay_timer.sv
// game_delay_timer: counts a requested number of prescaled ticks, then
// returns a one-cycle slowClk pulse to the game control FSM.
//
// Ports:
//   clk            system clock
//   resetN         asynchronous active-low reset
//   requestTime    start-delay strobe (retriggers a running delay)
//   slowClkRequest delay length in ticks, sampled with requestTime
//   freeze         holds prescaler and tick count while running (pause)
//   cancel         aborts a running delay without a pulse
//   slowClk        one-cycle delay-done pulse
//   busy           high while a delay is running
//   remaining      ticks still to elapse
module game_delay_timer #(
   parameter int unsigned TICK_DIV = 500000,
   parameter int unsigned REQ_W    = 11
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             requestTime,
   input  logic [REQ_W-1:0] slowClkRequest,
   input  logic             freeze,
   input  logic             cancel,
   output logic             slowClk,
   output logic             busy,
   output logic [REQ_W-1:0] remaining
);

   localparam int unsigned     PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [PRE_W-1:0] prescaler, prescaler_nxt;
   logic [REQ_W-1:0] remaining_nxt;

   // State, counters and decoded outputs; outputs are registered from next state
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= ST_IDLE;
         prescaler <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         slowClk   <= 1'b0;
      end else begin
         state     <= state_nxt;
         prescaler <= prescaler_nxt;
         remaining <= remaining_nxt;
         busy      <= (state_nxt == ST_RUN);
         slowClk   <= (state_nxt == ST_DONE);
      end
   end

   // Next-state: request beats cancel beats expiry
   always_comb begin
      state_nxt     = state;
      prescaler_nxt = prescaler;
      remaining_nxt = remaining;

      if (requestTime) begin
         prescaler_nxt = '0;
         if (slowClkRequest != '0) begin
            state_nxt     = ST_RUN;
            remaining_nxt = slowClkRequest;
         end else begin
            // zero-length delay answers immediately, never shows busy
            state_nxt     = ST_DONE;
            remaining_nxt = '0;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (cancel) begin
                  state_nxt     = ST_IDLE;
                  remaining_nxt = '0;
                  prescaler_nxt = '0;
               end else if (!freeze) begin
                  if (prescaler == PRE_LAST) begin
                     prescaler_nxt = '0;
                     remaining_nxt = remaining - REQ_W'(1);
                     // RUN always holds remaining >= 1, so no underflow
                     if (remaining == REQ_W'(1)) begin
                        state_nxt = ST_DONE;
                     end
                  end else begin
                     prescaler_nxt = prescaler + PRE_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_delay_timer.sv
// Testbench for game_delay_timer: directed scenarios plus random stimulus,
// all checked every cycle against a cycle-counting reference model.
module tb_game_delay_timer;

   localparam int unsigned TD    = 4;
   localparam int unsigned REQ_W = 11;

   logic             clk;
   logic             resetN;
   logic             requestTime;
   logic [REQ_W-1:0] slowClkRequest;
   logic             freeze;
   logic             cancel;
   logic             slowClk;
   logic             busy;
   logic [REQ_W-1:0] remaining;

   game_delay_timer #(.TICK_DIV(TD), .REQ_W(REQ_W)) dut (
      .clk            (clk),
      .resetN         (resetN),
      .requestTime    (requestTime),
      .slowClkRequest (slowClkRequest),
      .freeze         (freeze),
      .cancel         (cancel),
      .slowClk        (slowClk),
      .busy           (busy),
      .remaining      (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: a delay of n ticks expires after n*TD non-frozen cycles
   bit          m_run   = 1'b0;
   bit          m_pulse = 1'b0;
   int unsigned m_n     = 0;
   int unsigned m_act   = 0;

   int cyc       = 0;
   int pulses    = 0;
   int pulse_cyc = -1;
   int e0        = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_edge(input bit r, input int unsigned n, input bit f, input bit c);
      m_pulse = 1'b0;
      if (r) begin
         if (n > 0) begin
            m_run = 1'b1;
            m_n   = n;
            m_act = 0;
         end else begin
            m_run   = 1'b0;
            m_pulse = 1'b1;
         end
      end else if (m_run) begin
         if (c) begin
            m_run = 1'b0;
         end else if (!f) begin
            m_act++;
            if (m_act == m_n * TD) begin
               m_run   = 1'b0;
               m_pulse = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      int unsigned exp_rem;
      exp_rem = m_run ? (m_n - m_act / TD) : 0;
      check("slowClk", 32'(slowClk), 32'(m_pulse));
      check("busy", 32'(busy), 32'(m_run));
      check("remaining", 32'(remaining), exp_rem);
      if (slowClk) begin
         pulses++;
         pulse_cyc = cyc;
      end
   endtask

   // One clock: drive at negedge, model the edge, check at next negedge
   task automatic step(input bit r, input int unsigned n, input bit f, input bit c);
      requestTime    = r;
      slowClkRequest = REQ_W'(n);
      freeze         = f;
      cancel         = c;
      @(posedge clk);
      cyc++;
      model_edge(r, n, f, c);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic start(input int unsigned n);
      pulses    = 0;
      pulse_cyc = -1;
      step(1'b1, n, 1'b0, 1'b0);
      e0 = cyc;
   endtask

   initial begin
      resetN         = 1'b0;
      requestTime    = 1'b0;
      slowClkRequest = '0;
      freeze         = 1'b0;
      cancel         = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_slowClk", 32'(slowClk), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_remaining", 32'(remaining), 0);
      resetN = 1'b1;
      idle(2);

      // Basic delay
      start(3);
      idle(15);
      check("basic_pulses", pulses, 1);
      check("basic_at", pulse_cyc - e0, 12);

      // Zero-length request
      start(0);
      idle(5);
      check("zero_pulses", pulses, 1);
      check("zero_at", pulse_cyc - e0, 0);

      // Freeze for 5 cycles starting E0+2
      start(2);
      idle(1);
      for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 1'b0);
      idle(10);
      check("freeze_pulses", pulses, 1);
      check("freeze_at", pulse_cyc - e0, 13);

      // Retrigger at E0+6
      start(5);
      idle(5);
      step(1'b1, 1, 1'b0, 1'b0);
      idle(20);
      check("retrig_pulses", pulses, 1);
      check("retrig_at", pulse_cyc - e0, 10);

      // Cancel at E0+5
      start(3);
      idle(4);
      step(1'b0, 0, 1'b0, 1'b1);
      idle(20);
      check("cancel_pulses", pulses, 0);

      // Request on the expiring edge
      start(1);
      idle(3);
      step(1'b1, 2, 1'b0, 1'b0);
      idle(12);
      check("collide_pulses", pulses, 1);
      check("collide_at", pulse_cyc - e0, 12);

      // Reset mid-run at E0+7, asynchronous
      start(10);
      idle(6);
      #2 resetN = 1'b0;
      #1;
      check("async_rst_slowClk", 32'(slowClk), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_remaining", 32'(remaining), 0);
      m_run   = 1'b0;
      m_pulse = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      idle(45);
      check("rst_no_pulse", pulses, 0);
      start(1);
      idle(6);
      check("after_rst_pulses", pulses, 1);
      check("after_rst_at", pulse_cyc - e0, 4);

      // Maximum length
      start(2047);
      idle(2047 * TD + 2);
      check("max_pulses", pulses, 1);
      check("max_at", pulse_cyc - e0, 2047 * TD);

      // Random stimulus
      for (int i = 0; i < 4000; i++) begin
         bit          r, f, c;
         int unsigned n;
         r = ($urandom_range(0, 19) == 0);
         f = ($urandom_range(0, 5) == 0);
         c = ($urandom_range(0, 29) == 0);
         n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
         step(r, n, f, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
